fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch front end that owns the program counter, drives the instruction cache's lookup port every cycle it has space, and buffers returned instructions with their PCs in a small FIFO for the decode stage. It sits directly upstream of the instruction cache and directly downstream of branch/exception resolution. The cache's combinational hit/miss response is the fetch result. A miss holds the PC until the cache refills. A redirect flushes the buffer and restarts fetch at a new PC.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- FQ_DEPTH, 4: fetch-queue entries; power of two, at least 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- icache_req  out  1  lookup request to instruction cache.
- icache_addr  out  32  lookup address (current PC; bits [1:0] always 0).
- icache_instr  in  32  instruction returned by cache (valid when icache_hit).
- icache_hit  in  1  combinational hit for the current request.
- icache_miss  in  1  combinational miss for the current request.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored and forced to 0.
- fq_valid  out  1  queue head holds a valid instruction.
- fq_instr  out  32  head instruction; 0 when empty.
- fq_pc  out  32  head PC; 0 when empty.
- fq_ready  in  1  decode accepts head this cycle.
- fq_count  out  $clog2(FQ_DEPTH)+1  occupied entries.
- stall_cycles  out  32  count of cycles with icache_req=1 and icache_miss=1; saturates at 32'hFFFF_FFFF.

## Operation
- State
  - pc register.
  - run flag: 0 in reset, set on the first clock after reset release.
  - FQ_DEPTH x {pc, instr} storage.
  - wr_ptr and rd_ptr: $clog2(FQ_DEPTH) bits, wrap modulo FQ_DEPTH.
  - count register.
  - stall_cycles register.
- Request: icache_req = run && !redirect_valid && (count < FQ_DEPTH). icache_addr = pc at all times.
- Push when icache_req && icache_hit:
  - Write {pc, icache_instr} at wr_ptr.
  - wr_ptr += 1.
  - pc <= pc + 4, 32-bit wrap at 32'hFFFF_FFFC to 0.
- Miss (icache_req && icache_miss):
  - No push; pc holds.
  - stall_cycles += 1 unless saturated.
  - The fetch unit retries the same address every cycle until a hit.
- Pop when fq_valid && fq_ready: rd_ptr += 1.
- Push and pop in the same cycle: count unchanged; both pointers advance.
- Full (count == FQ_DEPTH):
  - icache_req = 0 and pc holds.
  - A pop in a full cycle does not enable a request in that same cycle (no full-cycle bypass). Fetch resumes the next cycle.
- Empty: fq_valid = 0, fq_instr = 0, fq_pc = 0. A pop attempted while empty is ignored.
- Redirect has priority over push and pop:
  - count, wr_ptr and rd_ptr cleared to 0.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - Any handshake in that cycle is discarded.
  - stall_cycles is not cleared.
- Reset (asynchronous, at any time, including mid-miss or mid-redirect) forces:
  - pc = RESET_PC, run = 0, count = 0, pointers = 0, stall_cycles = 0.
  - Outputs: icache_req = 0, fq_valid = 0, fq_instr = 0, fq_pc = 0, fq_count = 0, icache_addr = RESET_PC, stall_cycles = 0.
  - Storage contents are don't-care.

## Timing
- Cycle R: first rising edge with rst_n high; sets run.
- Cycle R+1: first request at RESET_PC.
- Hit in cycle N: entry visible at queue head (if queue was empty) in cycle N+1. Next PC requested in cycle N+1.
- Sustained hits with fq_ready=1: one instruction per cycle; fq_count stays at 1.
- Miss in cycle N: request repeats at the same PC in N+1. The cache refills on its mem_ready edge; the first hit is the cycle after that refill edge.
- Redirect in cycle N:
  - icache_req = 0 in N.
  - N+1: fq_valid = 0 and icache_addr = redirect_pc.
  - A hit in N+1 makes the redirect target visible in N+2.
- No combinational path from fq_ready to icache_req.
- Combinational paths: redirect_valid to icache_req, and icache_hit/icache_miss to state only.

## Test plan
- Reset, then 8 consecutive hits with fq_ready=1 -> first request at RESET_PC in cycle R+1. fq_pc sequence is 0x0, 0x4, …, 0x1C, one per cycle. stall_cycles=0.
- fq_ready=0 with continuous hits -> 4 pushes (PCs 0x0–0xC); fq_count=4; icache_req=0 and icache_addr=0x10 held. One pop -> one cycle later icache_req=1 and 0x10 pushed.
- Miss at PC 0x20 for 3 cycles, then hit -> icache_addr stays 0x20 for 4 cycles; stall_cycles=3; single entry with PC 0x20 pushed.
- Queue holding 3 entries, redirect_valid with redirect_pc=0x1003 -> next cycle fq_count=0, fq_valid=0, icache_addr=0x1000. Hit -> fq_pc=0x1000.
- Redirect asserted in the same cycle as a hit and a pop -> neither the push nor the pop takes effect; queue empty next cycle.
- rst_n dropped mid-miss with the queue non-empty -> all outputs at reset values immediately, without a clock edge. Fetch restarts at RESET_PC two cycles after release.

Source files
------------

// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, looks up the icache each cycle it has queue space, buffers {pc, instr} for decode.
// Hit in N is visible at the head in N+1; a full queue drops icache_req, and a redirect flushes and restarts at redirect_pc.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        icache_req,
  output logic [31:0]                 icache_addr,
  input  logic [31:0]                 icache_instr,
  input  logic                        icache_hit,
  input  logic                        icache_miss,
  input  logic                        redirect_valid,
  input  logic [31:0]                 redirect_pc,
  output logic                        fq_valid,
  output logic [31:0]                 fq_instr,
  output logic [31:0]                 fq_pc,
  input  logic                        fq_ready,
  output logic [$clog2(FQ_DEPTH):0]   fq_count,
  output logic [31:0]                 stall_cycles
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FQ_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  fq_entry_t         mem [FQ_DEPTH];
  fq_entry_t         head;
  logic [31:0]       pc;
  logic              run;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              push;
  logic              pop;

  // Request depends on the registered count only, so a pop never unblocks fetch in the same cycle.
  assign icache_req  = run && !redirect_valid && (count != FULL);
  assign icache_addr = pc;

  assign push = icache_req && icache_hit;
  assign pop  = fq_valid && fq_ready && !redirect_valid;

  assign head     = mem[rd_ptr];
  assign fq_valid = (count != '0);
  assign fq_instr = fq_valid ? head.instr : '0;
  assign fq_pc    = fq_valid ? head.pc : '0;
  assign fq_count = count;

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{pc: pc, instr: icache_instr};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      run          <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      stall_cycles <= '0;
    end else begin
      run <= 1'b1;
      if (icache_req && icache_miss && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (redirect_valid) begin
        pc     <= redirect_pc & 32'hFFFF_FFFC;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          pc     <= pc + 32'd4;
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit against a queue-based reference model and a hashed icache model.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic        clk;
  logic        rst_n;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic [31:0] icache_instr;
  logic        icache_hit;
  logic        icache_miss;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fq_valid;
  logic [31:0] fq_instr;
  logic [31:0] fq_pc;
  logic        fq_ready;
  logic [2:0]  fq_count;
  logic [31:0] stall_cycles;

  fetch_unit #(.RESET_PC(RESET_PC), .FQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .icache_req(icache_req), .icache_addr(icache_addr), .icache_instr(icache_instr),
    .icache_hit(icache_hit), .icache_miss(icache_miss),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fq_valid(fq_valid), .fq_instr(fq_instr), .fq_pc(fq_pc), .fq_ready(fq_ready),
    .fq_count(fq_count), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_pc;
  logic [31:0] m_stall;
  bit          m_run;
  bit          m_req;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  assign icache_instr = instr_of(icache_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".icache_req"},   32'(icache_req), 32'd0);
    chk({tag, ".fq_valid"},     32'(fq_valid), 32'd0);
    chk({tag, ".fq_instr"},     fq_instr, 32'd0);
    chk({tag, ".fq_pc"},        fq_pc, 32'd0);
    chk({tag, ".fq_count"},     32'(fq_count), 32'd0);
    chk({tag, ".icache_addr"},  icache_addr, RESET_PC);
    chk({tag, ".stall_cycles"}, stall_cycles, 32'd0);
  endtask

  task automatic model_reset();
    sb.delete();
    m_pc    = RESET_PC;
    m_stall = '0;
    m_run   = 1'b0;
  endtask

  // Release at a negedge; the following posedge sets run, so the model is already running for the next check.
  task automatic release_reset();
    @(negedge clk);
    rst_n          = 1'b1;
    icache_hit     = 1'b1;
    icache_miss    = 1'b0;
    fq_ready       = 1'b1;
    redirect_valid = 1'b0;
    #1;
    chk("req_before_run", 32'(icache_req), 32'd0);
    m_run = 1'b1;
  endtask

  // One cycle: drive at negedge, check at +1, monitor pops at +2, model advances at +3.
  task automatic cycle(input int hit_pct, input int ready_pct, input int redir_pct);
    int r;
    @(negedge clk);
    r              = $urandom_range(0, 99);
    icache_hit     = (r < hit_pct);
    icache_miss    = !icache_hit && ($urandom_range(0, 4) != 0);
    fq_ready       = ($urandom_range(0, 99) < ready_pct);
    redirect_valid = ($urandom_range(0, 99) < redir_pct);
    redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
    #1;
    m_req = m_run && !redirect_valid && (sb.size() < DEPTH);
    chk("icache_req",   32'(icache_req), 32'(m_req));
    chk("icache_addr",  icache_addr, m_pc);
    chk("fq_count",     32'(fq_count), 32'(sb.size()));
    chk("fq_valid",     32'(fq_valid), 32'(sb.size() != 0));
    chk("stall_cycles", stall_cycles, m_stall);
    if (sb.size() == 0) begin
      chk("empty_instr", fq_instr, 32'd0);
      chk("empty_pc",    fq_pc, 32'd0);
    end
    #2;
    if (redirect_valid) begin
      sb.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
    end else if (m_req && icache_hit) begin
      sb.push_back('{pc: m_pc, instr: instr_of(m_pc)});
      m_pc = m_pc + 32'd4;
    end
    if (m_req && icache_miss && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 32'd1;
  endtask

  // Monitor: whenever decode takes the head, it must match the oldest expected entry.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && fq_valid && fq_ready) begin
        if (sb.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL pop_unexpected: got pc %h with no entry expected at %0t", fq_pc, $time);
        end else begin
          e = sb.pop_front();
          chk("fq_pc",    fq_pc, e.pc);
          chk("fq_instr", fq_instr, e.instr);
        end
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    icache_hit     = 1'b0;
    icache_miss    = 1'b0;
    fq_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    model_reset();
    #1;
    check_reset_outputs("por");
    repeat (2) @(negedge clk);
    release_reset();

    repeat (12) cycle(100, 100, 0);   // streaming hits
    repeat (8)  cycle(100, 0, 0);     // fill to full
    cycle(100, 100, 0);               // single pop while full
    repeat (4)  cycle(100, 0, 0);
    repeat (20) cycle(20, 100, 0);    // miss-heavy
    repeat (1500) cycle(60, 50, 6);

    // Async reset mid-miss with a non-empty queue.
    repeat (3) cycle(100, 0, 0);
    repeat (3) cycle(0, 0, 0);
    @(negedge clk);
    #5;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    model_reset();
    repeat (2) @(negedge clk);
    release_reset();

    repeat (1500) cycle(75, 70, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
